piso_serial_scheduler: RTL and testbench

Two-requester scheduler that owns a WIDTH-bit parallel-in serial-out shift register and shares it between two word sources. It arbitrates round-robin and accepts one word per frame through a valid/ready handshake. It loads the winning word, then shifts it out LSB first with a frame strobe and source tag. Sits between word producers and a single-wire serial link.

---
 rtl/piso_serial_scheduler.sv | 167 ++++++++++++++++
 tb/tb_piso_serial_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serial_scheduler.sv
// Two-requester round-robin scheduler that shares one WIDTH-bit PISO shift register.
// Optional feature: define PISO_SCHED_PARITY_EN to append an even-parity bit to each frame.
module piso_serial_scheduler #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_src,
    output logic             busy
);

`ifdef PISO_SCHED_PARITY_EN
    localparam int unsigned SW = WIDTH + 1;
`else
    localparam int unsigned SW = WIDTH;
`endif
    localparam int unsigned CMAX     = (SW > GAP) ? SW : GAP;
    localparam int unsigned CW       = $clog2(CMAX);
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [CW-1:0] SHIFT_END = CW'(SW - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_LAST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_shreg;
    logic [CW-1:0]   r_cnt;
    logic            r_src;
    logic            r_ptr;
    logic            w_sel0;
    logic            w_sel1;
    logic            w_take;
    logic [WIDTH-1:0] w_word;
    logic [SW-1:0]   w_load;

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        w_sel0 = req0_valid && (!req1_valid || r_ptr);
        w_sel1 = req1_valid && (!req0_valid || !r_ptr);
    end

    always_comb begin
        w_word = w_sel1 ? req1_data : req0_data;
`ifdef PISO_SCHED_PARITY_EN
        w_load = {^w_word, w_word};
`else
        w_load = w_word;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == SHIFT_END) begin
                    if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_END) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic; readys are gated by rst so they drop immediately on reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ser_out    = 1'b0;
        ser_frame  = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req0_ready = !rst && w_sel0;
                req1_ready = !rst && w_sel1;
            end
            S_SHIFT: begin
                ser_out   = r_shreg[0];
                ser_frame = 1'b1;
            end
            default: begin
                ser_out   = 1'b0;
                ser_frame = 1'b0;
            end
        endcase
        w_take = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    end

    assign ser_src = r_src;

    // Datapath: shift register, bit/gap counter, source tag and last-served pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_src   <= 1'b0;
            r_ptr   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_shreg <= w_load;
                        r_src   <= req1_ready;
                        r_ptr   <= req1_ready;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shreg <= r_shreg >> 1;
                    if (r_cnt == SHIFT_END) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_END) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_scheduler.sv
// Self-checking bench for piso_serial_scheduler: timeline-based reference model plus
// hand-computed frame/latency expectations.
module tb_piso_serial_scheduler;

    localparam int W = 4;
    localparam int G = 1;
`ifdef PISO_SCHED_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB     = W + PB;
    localparam int PERIOD = FB + G + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data  = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data  = '0;
    logic         req1_ready;
    logic         ser_out;
    logic         ser_frame;
    logic         ser_src;
    logic         busy;

    int total = 0;
    int bad   = 0;

    piso_serial_scheduler #(.WIDTH(W), .GAP(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .ser_src    (ser_src),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: timeline of the last transfer.
    int           n = 0;
    int           m_x = -1000;
    int           m_free = 0;
    int           m_ptr = 1;
    int           m_src = 0;
    logic [W-1:0] m_word = '0;

    // Logs captured from the DUT, pinned later by literal expectations.
    int           xn = 0;
    int           x_src [0:15];
    int           x_cyc [0:15];
    int           fn = 0;
    logic [7:0]   frames [0:15];
    logic [7:0]   cur = '0;
    int           cur_n = 0;

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready0", int'(req0_ready), 0);
            chk("rst_ready1", int'(req1_ready), 0);
            chk("rst_ser_out", int'(ser_out), 0);
            chk("rst_ser_frame", int'(ser_frame), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ser_src", int'(ser_src), 0);
            m_x = -1000; m_free = n; m_ptr = 1; m_src = 0;
            cur = '0; cur_n = 0;
        end else begin
            bit idle, e_r0, e_r1, e_fr, e_bit;
            int off;
            idle  = (n >= m_free);
            e_r0  = idle && req0_valid && (!req1_valid || m_ptr == 1);
            e_r1  = idle && req1_valid && (!req0_valid || m_ptr == 0);
            off   = n - m_x;
            e_fr  = (off >= 1) && (off <= FB);
            e_bit = 1'b0;
            if (e_fr) e_bit = (off - 1 < W) ? m_word[off-1] : ^m_word;
            chk("ready0", int'(req0_ready), int'(e_r0));
            chk("ready1", int'(req1_ready), int'(e_r1));
            chk("ser_frame", int'(ser_frame), int'(e_fr));
            chk("ser_out", int'(ser_out), int'(e_bit));
            chk("busy", int'(busy), int'(!idle));
            chk("ser_src", int'(ser_src), m_src);
            if (ser_frame) begin
                cur[cur_n] = ser_out;
                cur_n++;
                if (cur_n == FB) begin
                    if (fn < 16) frames[fn] = cur;
                    fn++; cur = '0; cur_n = 0;
                end
            end
            if (req0_ready && req0_valid && xn < 16) begin
                x_src[xn] = 0; x_cyc[xn] = n; xn++;
            end
            if (req1_ready && req1_valid && xn < 16) begin
                x_src[xn] = 1; x_cyc[xn] = n; xn++;
            end
            if (e_r0 || e_r1) begin
                m_x = n; m_free = n + PERIOD;
                m_ptr = e_r1 ? 1 : 0; m_src = m_ptr;
                m_word = e_r1 ? req1_data : req0_data;
            end
        end
        n++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_accept(input int who, output int waited);
        waited = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((who == 0 && req0_ready && req0_valid) || (who == 1 && req1_ready && req1_valid)) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout: requester %0d never accepted", who);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (ok == 0) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy never fell");
        end
        tick();
    endtask

    task automatic chk_frame(input int idx, input int e_nopar, input int e_par);
        if (idx < fn) chk($sformatf("frame%0d", idx), int'(frames[idx]), (PB == 1) ? e_par : e_nopar);
        else begin
            total++; bad++;
            $display("FAIL frame%0d_missing: got %0d frames expected more", idx, fn);
        end
    endtask

    task automatic chk_src(input int idx, input int e);
        if (idx < xn) chk($sformatf("xfer%0d_src", idx), x_src[idx], e);
        else begin
            total++; bad++;
            $display("FAIL xfer%0d_missing: got %0d transfers expected more", idx, xn);
        end
    endtask

    initial begin
        int w;
        // Reset held with both valids high.
        req0_valid = 1'b1; req0_data = 4'hA;
        req1_valid = 1'b1; req1_data = 4'h5;
        repeat (4) tick();
        rst = 1'b0;
        wait_accept(0, w);
        chk("first_accept_wait", w, 0);
        req0_valid = 1'b0;
        wait_accept(1, w);
        req1_valid = 1'b0;
        wait_idle();

        // req0 alone: 1011 then 0111.
        req0_valid = 1'b1; req0_data = 4'b1011;
        wait_accept(0, w);
        req0_data = 4'b0111;
        wait_accept(0, w);
        req0_valid = 1'b0;
        wait_idle();

        // req1 continuous, req0 arrives mid-frame.
        req1_valid = 1'b1; req1_data = 4'h3;
        wait_accept(1, w);
        tick(); tick();
        req0_valid = 1'b1; req0_data = 4'hC;
        wait_accept(0, w);
        req0_valid = 1'b0;
        wait_accept(1, w);
        req1_valid = 1'b0;
        wait_idle();

        // Reset asserted during bit 2 of a frame.
        req0_valid = 1'b1; req0_data = 4'h6;
        wait_accept(0, w);
        req0_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_frame", int'(ser_frame), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_frame", int'(ser_frame), 0);
        chk("async_rst_out", int'(ser_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 4'h9;
        req1_valid = 1'b1; req1_data = 4'h6;
        wait_accept(0, w);
        chk("post_rst_accept_wait", w, 0);
        req0_valid = 1'b0;
        wait_accept(1, w);
        req1_valid = 1'b0;
        wait_idle();

        // Hand-computed expectations.
        chk_src(0, 0); chk_src(1, 1);
        if (xn > 1) chk("tie_spacing", x_cyc[1] - x_cyc[0], (PB == 1) ? 7 : 6);
        chk_src(2, 0); chk_src(3, 0);
        if (xn > 3) chk("b2b_spacing", x_cyc[3] - x_cyc[2], (PB == 1) ? 7 : 6);
        chk_src(4, 1); chk_src(5, 0); chk_src(6, 1);
        chk_src(7, 0); chk_src(8, 0); chk_src(9, 1);
        chk("xfer_count", xn, 10);
        chk_frame(0, 'h0A, 'h0A);
        chk_frame(1, 'h05, 'h05);
        chk_frame(2, 'h0B, 'h1B);
        chk_frame(3, 'h07, 'h17);
        chk_frame(4, 'h03, 'h03);
        chk_frame(5, 'h0C, 'h0C);
        chk_frame(6, 'h03, 'h03);
        chk_frame(7, 'h09, 'h09);
        chk_frame(8, 'h06, 'h06);
        chk("frame_count", fn, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
